mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the data width.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles before the transaction is aborted.
REQ-004 clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 a_req, a_we  in  1 each  SHALL be the port A request and write-select (1 = write).
REQ-007 a_addr  in  ADDR_W; a_wdata  in  DATA_W  SHALL be the port A address and write data.
REQ-008 a_gnt, a_done  out  1 each  SHALL be the port A accept pulse and completion pulse.
REQ-009 b_req, b_we, b_addr, b_wdata, b_gnt, b_done SHALL mirror the port A signals for port B, with identical widths.
REQ-010 rdata  out  DATA_W  SHALL be the read result, shared by both ports.
REQ-011 timeout_err  out  1  SHALL be a sticky timeout flag.
REQ-012 mem_addr  out  ADDR_W; mem_d  out  DATA_W  SHALL be the address and write data driven to the SRAM controller.
REQ-013 mem_rd, mem_wr  out  1 each  SHALL be the single-cycle read and write strobes to the SRAM controller.
REQ-014 mem_q  in  DATA_W; mem_mwait  in  1  SHALL be the SRAM controller read data and busy flag.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE with no request asserted, the FSM SHALL remain in IDLE and all strobes and pulses SHALL be 0.
REQ-017 In IDLE with at least one request, the block SHALL select a winner, latch its we, addr, wdata and owner, and go to ISSUE.
REQ-018 When exactly one port requests, that port SHALL win.
REQ-019 When both ports request in the same cycle, the port not granted most recently SHALL win (round-robin).
REQ-020 In ISSUE, the registered outputs SHALL assert mem_rd (we = 0) or mem_wr (we = 1) for exactly that one cycle, and the winner's gnt SHALL be 1 for that same cycle; the FSM SHALL then go to WAIT.
REQ-021 mem_addr and mem_d SHALL hold the latched values from ISSUE through DONE inclusive.
REQ-022 In WAIT, a cycle counter SHALL increment every cycle.
REQ-023 In WAIT, if mem_mwait = 0 the block SHALL capture rdata <= mem_q (reads only; rdata SHALL be unchanged for writes) and go to DONE.
REQ-024 In WAIT, if the counter reaches TIMEOUT with mem_mwait still 1, the block SHALL set timeout_err, leave rdata unchanged and go to DONE.
REQ-025 In DONE, the owner's done SHALL be 1 for exactly one cycle, and rdata SHALL be valid in that cycle for reads; the FSM SHALL then go to IDLE.
REQ-026 Requests arriving outside IDLE SHALL be ignored.
REQ-027 Requesters SHALL hold req, we, addr and wdata until their gnt pulse.
REQ-028 A req still asserted when the FSM returns to IDLE SHALL be treated as a new request.
REQ-029 With a 3-cycle-busy SRAM controller, a read SHALL complete as: cycle 0 IDLE, cycle 1 ISSUE, cycles 2-4 WAIT, cycle 5 DONE; this gives a 5-cycle latency from the req-sampled edge to done.
REQ-030 gnt and done SHALL never be asserted to both ports in the same cycle.
REQ-031 mem_rd and mem_wr SHALL never be asserted together.
REQ-032 timeout_err SHALL be cleared only by reset.

Reset
REQ-033 While reset = 0, the FSM SHALL be IDLE; mem_rd, mem_wr, a_gnt, b_gnt, a_done, b_done and timeout_err SHALL be 0; rdata, mem_addr, mem_d and the WAIT counter SHALL be 0; and last-granted SHALL be B, so that A wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction immediately and asynchronously, with no done pulse.
REQ-035 After reset release, operation SHALL begin in IDLE on the next rising edge.

Verification
REQ-036 Single A read at addr 0x005, SRAM model returning 0xBEEF with mwait high for 3 cycles -> a_gnt in cycle 1, mem_rd high only in cycle 1, a_done with rdata = 0xBEEF in cycle 5.
REQ-037 B write of 0x1234 to 0x3FF -> mem_wr for one cycle with mem_addr = 0x3FF and mem_d = 0x1234; b_done asserted; rdata unchanged.
REQ-038 a_req and b_req held continuously for 4 transactions -> grant order A, B, A, B; done pulses never overlap.
REQ-039 mem_mwait stuck at 1 -> timeout_err set after 15 WAIT cycles, done pulse to owner, next request still served, timeout_err remains 1.
REQ-040 Reset asserted during WAIT -> mem_rd, mem_wr and done go to 0 immediately, FSM in IDLE, no done pulse after release.
REQ-041 b_req asserted during an A transaction -> B not granted until the FSM returns to IDLE, then b_gnt asserted in the following ISSUE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-access SRAM controller
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_mwait
);

    // Wide enough to hold TIMEOUT itself so the last WAIT cycle's increment never wraps.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                owner_b_q, owner_b_d;    // 1 = port B owns the transaction
    logic                last_b_q, last_b_d;      // 1 = port B was granted most recently
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tmo_q, tmo_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                a_gnt_q, a_gnt_d;
    logic                b_gnt_q, b_gnt_d;
    logic                a_done_q, a_done_d;
    logic                b_done_q, b_done_d;

    logic                sel_b;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Pick the requester for the next transaction: lone requester wins, a tie goes to the port not served last.
    always_comb begin
        if (a_req && b_req) begin
            sel_b = !last_b_q;
        end else begin
            sel_b = b_req;
        end
        sel_we    = sel_b ? b_we    : a_we;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
    end

    // Next-state and next-output logic; strobes and pulses are one-cycle and default low.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        owner_b_d = owner_b_q;
        last_b_d  = last_b_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        a_gnt_d   = 1'b0;
        b_gnt_d   = 1'b0;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    owner_b_d = sel_b;
                    last_b_d  = sel_b;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    mem_rd_d  = !sel_we;
                    mem_wr_d  = sel_we;
                    a_gnt_d   = !sel_b;
                    b_gnt_d   = sel_b;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_mwait) begin
                    if (!we_q) begin
                        rdata_d = mem_q;
                    end
                    a_done_d = !owner_b_q;
                    b_done_d = owner_b_q;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d    = 1'b1;
                    a_done_d = !owner_b_q;
                    b_done_d = owner_b_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            owner_b_q <= owner_b_d;
            last_b_q  <= last_b_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
        end
    end

    assign a_gnt       = a_gnt_q;
    assign b_gnt       = b_gnt_q;
    assign a_done      = a_done_q;
    assign b_done      = b_done_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = addr_q;
    assign mem_d       = wdata_q;
    assign rdata       = rdata_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_done, b_gnt, b_done;
    logic [DW-1:0] rdata;
    logic          timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_q;
    logic          mem_mwait;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_next = 3;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done),
        .rdata(rdata), .timeout_err(timeout_err),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_q(mem_q), .mem_mwait(mem_mwait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 16'hBEEF;
        return DW'(a * 257) ^ 16'h5A5A;
    endfunction

    task automatic new_fields(output logic we, output logic [AW-1:0] addr, output logic [DW-1:0] d);
        we   = 1'($urandom_range(1, 0));
        addr = ($urandom_range(7, 0) == 0) ? AW'(10'h3FF) : AW'($urandom_range(31, 0));
        d    = DW'($urandom);
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(9, 0));
        if (r <= 5) return r;
        if (r == 6) return TMO;
        if (r == 7) return TMO + 1;
        if (r == 8) return 40;
        return 2;
    endfunction

    // Transaction-level reference model plus SRAM controller model, evaluated mid-cycle.
    initial begin
        int cyc, t_issue, t_done, t_lat, busy, w;
        bit have, t_b, t_we, t_tmo, last_b, e_tmo, issue_now, done_now;
        logic [AW-1:0] t_addr, e_addr;
        logic [DW-1:0] t_wdata, t_rval, e_d, e_rdata;
        logic [DW-1:0] sram [1 << AW];
        logic [DW-1:0] ref_mem [1 << AW];
        cyc = 0; t_issue = 0; t_done = 0; t_lat = 0; busy = 0; w = 0;
        have = 0; t_b = 0; t_we = 0; t_tmo = 0; last_b = 1; e_tmo = 0;
        t_addr = '0; e_addr = '0; t_wdata = '0; t_rval = '0; e_d = '0; e_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = init_val(i);
            ref_mem[i] = init_val(i);
        end
        mem_q     = '0;
        mem_mwait = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                have = 0; last_b = 1; e_addr = '0; e_d = '0; e_rdata = '0; e_tmo = 0;
            end else begin
                if (have && cyc > t_done) have = 0;
                if (!have && (a_req || b_req)) begin
                    if (a_req && b_req) t_b = last_b ? 1'b0 : 1'b1;
                    else                t_b = b_req;
                    last_b  = t_b;
                    t_we    = t_b ? b_we    : a_we;
                    t_addr  = t_b ? b_addr  : a_addr;
                    t_wdata = t_b ? b_wdata : a_wdata;
                    t_lat   = lat_next;
                    w       = (t_lat < 1) ? 1 : t_lat;
                    t_tmo   = (t_lat > TMO);
                    if (w > TMO) w = TMO;
                    t_issue = cyc + 1;
                    t_done  = cyc + 2 + w;
                    have    = 1;
                    if (t_we) ref_mem[t_addr] = t_wdata;
                    else      t_rval = ref_mem[t_addr];
                end
                if (have && cyc == t_issue) begin
                    e_addr = t_addr;
                    e_d    = t_wdata;
                end
                if (have && cyc == t_done) begin
                    if (t_tmo)      e_tmo = 1;
                    else if (!t_we) e_rdata = t_rval;
                end
            end
            issue_now = rst_n && have && (cyc == t_issue);
            done_now  = rst_n && have && (cyc == t_done);
            check_eq("a_gnt",       a_gnt,       issue_now && !t_b);
            check_eq("b_gnt",       b_gnt,       issue_now && t_b);
            check_eq("mem_rd",      mem_rd,      issue_now && !t_we);
            check_eq("mem_wr",      mem_wr,      issue_now && t_we);
            check_eq("a_done",      a_done,      done_now && !t_b);
            check_eq("b_done",      b_done,      done_now && t_b);
            check_eq("mem_addr",    mem_addr,    e_addr);
            check_eq("mem_d",       mem_d,       e_d);
            check_eq("rdata",       rdata,       e_rdata);
            check_eq("timeout_err", timeout_err, e_tmo);
            if (!rst_n) begin
                busy = 0;
            end else if (mem_rd || mem_wr) begin
                busy = t_lat;
                if (mem_wr) sram[mem_addr] = mem_d;
            end else if (busy > 0) begin
                busy--;
            end
            mem_q     = sram[mem_addr];
            mem_mwait = (busy > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on one port; cycle 0 is the cycle the request is first presented.
    task automatic do_txn(input bit port_b, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] d, input int lat,
                          output int kg, output int kd, output logic s_rd, output logic s_wr,
                          output logic [AW-1:0] s_addr, output logic [DW-1:0] s_d);
        lat_next = lat;
        kg = -1; kd = -1; s_rd = 0; s_wr = 0; s_addr = '0; s_d = '0;
        if (port_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = d; end
        else        begin a_req = 1; a_we = we; a_addr = addr; a_wdata = d; end
        for (int k = 0; k < 80 && kd < 0; k++) begin
            @(negedge clk);
            if ((port_b ? b_gnt : a_gnt) && kg < 0) begin
                kg = k; s_rd = mem_rd; s_wr = mem_wr; s_addr = mem_addr; s_d = mem_d;
            end
            if (port_b ? b_done : a_done) begin
                kd = k;
            end else begin
                @(posedge clk);
                #1;
                if (kg >= 0) begin
                    if (port_b) b_req = 0;
                    else        a_req = 0;
                end
            end
        end
        check_eq("txn_done_seen", kd >= 0, 1);
    endtask

    initial begin
        int kg, kd, kb, ov, dn;
        logic s_rd, s_wr, ag, bg;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_d;
        int gr[$];
        rst_n = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_strobes", {mem_rd, mem_wr, a_gnt, b_gnt, a_done, b_done}, 0);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        rst_n = 1;

        do_txn(0, 0, 10'h005, 16'h0000, 3, kg, kd, s_rd, s_wr, s_addr, s_d);
        check_eq("rdA_gnt_cycle", kg, 1);
        check_eq("rdA_rd_strobe", s_rd, 1);
        check_eq("rdA_done_cycle", kd, 5);
        check_eq("rdA_data", rdata, 16'hBEEF);
        step();

        do_txn(1, 1, 10'h3FF, 16'h1234, 2, kg, kd, s_rd, s_wr, s_addr, s_d);
        check_eq("wrB_wr_strobe", {s_rd, s_wr}, 2'b01);
        check_eq("wrB_addr", s_addr, 10'h3FF);
        check_eq("wrB_data", s_d, 16'h1234);
        check_eq("wrB_done_cycle", kd, 4);
        check_eq("wrB_rdata_kept", rdata, 16'hBEEF);
        step();

        do_txn(0, 0, 10'h010, 16'h0000, 40, kg, kd, s_rd, s_wr, s_addr, s_d);
        check_eq("tmo_done_cycle", kd, 2 + TMO);
        check_eq("tmo_flag", timeout_err, 1);
        check_eq("tmo_rdata_kept", rdata, 16'hBEEF);
        step();
        do_txn(1, 0, 10'h006, 16'h0000, 1, kg, kd, s_rd, s_wr, s_addr, s_d);
        check_eq("post_tmo_done_cycle", kd, 3);
        check_eq("post_tmo_rdata", rdata, init_val(6));
        check_eq("tmo_sticky", timeout_err, 1);
        step();

        do_txn(0, 0, 10'h020, 16'h0000, TMO, kg, kd, s_rd, s_wr, s_addr, s_d);
        check_eq("edge15_done_cycle", kd, 2 + TMO);
        check_eq("edge15_rdata", rdata, init_val(32));
        step();
        do_txn(0, 0, 10'h021, 16'h0000, TMO + 1, kg, kd, s_rd, s_wr, s_addr, s_d);
        check_eq("edge16_done_cycle", kd, 2 + TMO);
        check_eq("edge16_rdata_kept", rdata, init_val(32));
        step();

        lat_next = 12;
        a_req = 1; a_we = 0; a_addr = 10'h030;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        check_eq("arst_strobes", {mem_rd, mem_wr, a_done, b_done, a_gnt, b_gnt}, 0);
        check_eq("arst_rdata", rdata, 0);
        check_eq("arst_timeout", timeout_err, 0);
        check_eq("arst_mem_addr", mem_addr, 0);
        a_req = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        dn = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (a_done || b_done) dn++;
        end
        check_eq("arst_no_done", dn, 0);
        step();

        gr.delete();
        ov = 0;
        lat_next = 1;
        a_req = 1; new_fields(a_we, a_addr, a_wdata);
        b_req = 1; new_fields(b_we, b_addr, b_wdata);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            ag = a_gnt; bg = b_gnt;
            if (a_done && b_done) ov++;
            if (gr.size() < 4) begin
                if (ag) gr.push_back(0);
                if (bg) gr.push_back(1);
            end
            @(posedge clk);
            #1;
            if (gr.size() >= 4) begin
                a_req = 0; b_req = 0;
            end else begin
                if (ag) new_fields(a_we, a_addr, a_wdata);
                if (bg) new_fields(b_we, b_addr, b_wdata);
            end
        end
        check_eq("rr_count", gr.size(), 4);
        for (int i = 0; i < gr.size(); i++) check_eq($sformatf("rr_grant%0d", i), gr[i], i % 2);
        check_eq("rr_done_overlap", ov, 0);

        kb = -1;
        lat_next = 3;
        a_req = 1; a_we = 0; a_addr = 10'h040;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ag = a_gnt; bg = b_gnt;
            if (bg && kb < 0) kb = k;
            @(posedge clk);
            #1;
            if (k == 1) begin b_req = 1; b_we = 0; b_addr = 10'h041; end
            if (ag) a_req = 0;
            if (bg) b_req = 0;
        end
        check_eq("late_b_gnt_cycle", kb, 7);

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            ag = a_gnt; bg = b_gnt;
            @(posedge clk);
            #1;
            if (a_req) begin
                if (ag) begin
                    if ($urandom_range(1, 0) == 1) new_fields(a_we, a_addr, a_wdata);
                    else a_req = 0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                a_req = 1; new_fields(a_we, a_addr, a_wdata);
            end
            if (b_req) begin
                if (bg) begin
                    if ($urandom_range(1, 0) == 1) new_fields(b_we, b_addr, b_wdata);
                    else b_req = 0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                b_req = 1; new_fields(b_we, b_addr, b_wdata);
            end
            lat_next = pick_lat();
        end
        a_req = 0; b_req = 0;
        repeat (30) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
